// File: rtl/alu_pkg.sv
// Shared types for the ALU issue sequencer: opcodes, instruction layout, FSM states
// and the per-opcode register-usage decode.
package alu_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;
    localparam int REG_W   = 2;
    localparam int IMM_W   = 6;

    typedef enum logic [OP_W-1:0] {
        OP_OR     = 4'h0,
        OP_AND    = 4'h1,
        OP_XOR    = 4'h2,
        OP_NOT    = 4'h3,
        OP_SHL    = 4'h4,
        OP_SHR    = 4'h5,
        OP_INC    = 4'h6,
        OP_ADD    = 4'h7,
        OP_ADDC   = 4'h8,
        OP_SUB    = 4'h9,
        OP_LOADLO = 4'hA,
        OP_LOADHI = 4'hB,
        OP_OUT    = 4'hC,
        OP_HALT   = 4'hD,
        OP_NOP_E  = 4'hE,
        OP_NOP_F  = 4'hF
    } opcode_t;

    // Packed MSB-first: [15:12] op, [11:10] rd, [9:8] rx, [7:6] ry, [5:0] imm
    typedef struct packed {
        opcode_t              op;
        logic [REG_W-1:0]     rd;
        logic [REG_W-1:0]     rx;
        logic [REG_W-1:0]     ry;
        logic [IMM_W-1:0]     imm;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_STALL  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    function automatic logic uses_rx(opcode_t op);
        return (op <= OP_SUB) || (op == OP_OUT) || (op == OP_HALT);
    endfunction

    function automatic logic uses_ry(opcode_t op);
        return op inside {OP_OR, OP_AND, OP_XOR, OP_ADD, OP_ADDC, OP_SUB};
    endfunction

    // LOADLO/LOADHI merge the immediate into the old rd contents.
    function automatic logic uses_rd(opcode_t op);
        return op inside {OP_LOADLO, OP_LOADHI};
    endfunction

    function automatic logic writes_rd(opcode_t op);
        return op <= OP_LOADHI;
    endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Single-entry writeback scoreboard for the issue sequencer.
// Active only when ALU_SEQ_INTERLOCK_EN is defined; otherwise hazard_o is tied low.
module alu_scoreboard
    import alu_pkg::*;
#(
    parameter int WB_LAT = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             issue_i,
    input  logic             we_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic [REG_W-1:0] rx_i,
    input  logic [REG_W-1:0] ry_i,
    input  logic             use_rx_i,
    input  logic             use_ry_i,
    input  logic             use_rd_i,
    output logic             hazard_o
);

`ifdef ALU_SEQ_INTERLOCK_EN
    logic [REG_W-1:0] pending_rd_q, pending_rd_d;
    logic [1:0]       pending_cnt_q, pending_cnt_d;

    always_comb begin
        pending_rd_d  = pending_rd_q;
        pending_cnt_d = pending_cnt_q;
        if (clear_i) begin
            pending_cnt_d = 2'd0;
        end else if (issue_i && we_i) begin
            pending_rd_d  = rd_i;
            pending_cnt_d = 2'(WB_LAT);
        end else if (pending_cnt_q != 2'd0) begin
            pending_cnt_d = pending_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_rd_q  <= '0;
            pending_cnt_q <= 2'd0;
        end else begin
            pending_rd_q  <= pending_rd_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign hazard_o = (pending_cnt_q != 2'd0) &&
                      ((use_rx_i && (rx_i == pending_rd_q)) ||
                       (use_ry_i && (ry_i == pending_rd_q)) ||
                       (use_rd_i && (rd_i == pending_rd_q)));
`else
    logic unused_sb;
    assign unused_sb = ^{clk_i, reset_i, clear_i, issue_i, we_i, rd_i, rx_i, ry_i,
                         use_rx_i, use_ry_i, use_rd_i};
    assign hazard_o  = 1'b0;
`endif

endmodule

// File: rtl/alu_issue_seq.sv
// Fetch/decode/issue sequencer for the 12-bit ALU datapath, one instruction at a time.
// ALU_SEQ_INTERLOCK_EN enables the read-after-write interlock (scoreboard + STALL).
//
// state   | meaning
// IDLE    | waiting for start after reset
// FETCH   | imem_req held at pc until imem_ack
// ISSUE   | instruction register loaded; issue now unless hazard
// STALL   | waiting for the in-flight writeback to clear the hazard
// HALTED  | HALT issued; waiting for start
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int WB_LAT = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               issue_valid_o,
    output logic [OP_W-1:0]    issue_op_o,
    output logic [REG_W-1:0]   issue_rd_o,
    output logic [REG_W-1:0]   issue_rx_o,
    output logic [REG_W-1:0]   issue_ry_o,
    output logic [IMM_W-1:0]   issue_imm_o,
    output logic               issue_we_o,
    output logic               busy_o,
    output logic               halted_o,
    output logic [PC_W-1:0]    pc_o
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    instr_t          ir_q, ir_d;
    logic            we_q, we_d;
    logic            halted_q, halted_d;
    logic            sb_clear;
    logic            issue_valid;
    logic            hazard;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        we_d        = we_q;
        halted_d    = halted_q;
        sb_clear    = 1'b0;
        issue_valid = 1'b0;
        imem_req_o  = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start_i) begin
                    pc_d     = '0;
                    halted_d = 1'b0;
                    sb_clear = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_d    = instr_t'(imem_data_i);
                    we_d    = writes_rd(ir_d.op);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE, S_STALL: begin
                if (!hazard) begin
                    issue_valid = 1'b1;
                    if (ir_q.op == OP_HALT) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_STALL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            we_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            we_q     <= we_d;
            halted_q <= halted_d;
        end
    end

    alu_scoreboard #(
        .WB_LAT (WB_LAT)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (sb_clear),
        .issue_i  (issue_valid),
        .we_i     (we_q),
        .rd_i     (ir_q.rd),
        .rx_i     (ir_q.rx),
        .ry_i     (ir_q.ry),
        .use_rx_i (uses_rx(ir_q.op)),
        .use_ry_i (uses_ry(ir_q.op)),
        .use_rd_i (uses_rd(ir_q.op)),
        .hazard_o (hazard)
    );

    assign imem_addr_o   = pc_q;
    assign issue_valid_o = issue_valid;
    assign issue_op_o    = ir_q.op;
    assign issue_rd_o    = ir_q.rd;
    assign issue_rx_o    = ir_q.rx;
    assign issue_ry_o    = ir_q.ry;
    assign issue_imm_o   = ir_q.imm;
    assign issue_we_o    = we_q;
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted_o      = halted_q;
    assign pc_o          = pc_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Randomized bench for alu_issue_seq: instruction streams with random memory latency
// and spurious acks, checked against a cycle-time model of fetch, interlock and halt.
module tb_alu_issue_seq;

    localparam int PC_W   = 8;
    localparam int WB_LAT = 2;
`ifdef ALU_SEQ_INTERLOCK_EN
    localparam bit INTERLOCK = 1'b1;
`else
    localparam bit INTERLOCK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_data;
    logic            issue_valid;
    logic [3:0]      issue_op;
    logic [1:0]      issue_rd, issue_rx, issue_ry;
    logic [5:0]      issue_imm;
    logic            issue_we;
    logic            busy, halted;
    logic [PC_W-1:0] pc;

    int checks   = 0;
    int failures = 0;
    logic [15:0] stream[$];

    always #5 clk = ~clk;

    alu_issue_seq #(.PC_W(PC_W), .WB_LAT(WB_LAT)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .issue_valid_o (issue_valid),
        .issue_op_o    (issue_op),
        .issue_rd_o    (issue_rd),
        .issue_rx_o    (issue_rx),
        .issue_ry_o    (issue_ry),
        .issue_imm_o   (issue_imm),
        .issue_we_o    (issue_we),
        .busy_o        (busy),
        .halted_o      (halted),
        .pc_o          (pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Does instruction ins read register r (as a source operand)?
    function automatic bit reads_reg(input logic [15:0] ins, input logic [1:0] r);
        int op;
        bit rx_used, ry_used, rd_used;
        op      = int'(ins[15:12]);
        rx_used = (op <= 9) || (op == 12) || (op == 13);
        ry_used = (op <= 2) || (op >= 7 && op <= 9);
        rd_used = (op == 10) || (op == 11);
        return (rx_used && ins[9:8] == r) || (ry_used && ins[7:6] == r) ||
               (rd_used && ins[11:10] == r);
    endfunction

    // Runs the queued stream (last entry HALT) from a start pulse; memory acks after
    // 0..max_wait FETCH cycles. Issue of the n-th instruction is expected one cycle after
    // its ack, pushed out to lastwrite+WB_LAT+1 when it reads the last written register.
    task automatic run_prog(input int max_wait);
        int          cyc, k, waitc, exp_iss, tw;
        bit          fetching, done;
        logic [1:0]  rdw;
        logic [15:0] cur;
        @(negedge clk);
        start    = 1'b1;
        imem_ack = 1'b0;
        @(negedge clk);
        cyc = 0; k = 0; fetching = 1'b1; done = 1'b0;
        waitc = int'($urandom_range(max_wait, 0));
        tw = -100; rdw = 2'd0; exp_iss = -1; cur = 16'h0;
        while (!done && cyc < 20000) begin
            start     = ($urandom_range(15, 0) == 0);
            imem_ack  = 1'b0;
            imem_data = 16'($urandom);
            if (fetching) begin
                check("fetch_req", 32'(imem_req), 32'd1);
                check("fetch_addr", 32'(imem_addr), 32'(k % (1 << PC_W)));
                check("fetch_valid", 32'(issue_valid), 32'd0);
                check("fetch_busy", 32'(busy), 32'd1);
                if (waitc == 0) begin
                    cur       = stream[k];
                    imem_ack  = 1'b1;
                    imem_data = cur;
                    exp_iss   = cyc + 1;
                    if (INTERLOCK && reads_reg(cur, rdw) && (tw + WB_LAT + 1 > exp_iss))
                        exp_iss = tw + WB_LAT + 1;
                    fetching = 1'b0;
                end else begin
                    waitc--;
                end
            end else begin
                check("wait_req", 32'(imem_req), 32'd0);
                if ($urandom_range(3, 0) == 0) imem_ack = 1'b1;
                if (cyc == exp_iss) begin
                    check("iss_valid", 32'(issue_valid), 32'd1);
                    check("iss_op",  32'(issue_op),  32'(cur[15:12]));
                    check("iss_rd",  32'(issue_rd),  32'(cur[11:10]));
                    check("iss_rx",  32'(issue_rx),  32'(cur[9:8]));
                    check("iss_ry",  32'(issue_ry),  32'(cur[7:6]));
                    check("iss_imm", 32'(issue_imm), 32'(cur[5:0]));
                    check("iss_we",  32'(issue_we),  32'(cur[15:12] <= 4'hB));
                    check("iss_pc",  32'(pc),        32'(k % (1 << PC_W)));
                    if (cur[15:12] <= 4'hB) begin
                        tw  = cyc;
                        rdw = cur[11:10];
                    end
                    if (cur[15:12] == 4'hD) begin
                        done = 1'b1;
                    end else begin
                        k++;
                        fetching = 1'b1;
                        waitc    = int'($urandom_range(max_wait, 0));
                    end
                end else begin
                    check("stall_valid", 32'(issue_valid), 32'd0);
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("run_timeout", 32'(done), 32'd1);
        start    = 1'b0;
        imem_ack = 1'b0;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_valid", 32'(issue_valid), 32'd0);
        check("halt_pc", 32'(pc), 32'(k % (1 << PC_W)));
        for (int i = 0; i < 4; i++) begin
            imem_ack = ($urandom_range(1, 0) == 1);
            @(negedge clk);
            check("halt_no_req", 32'(imem_req), 32'd0);
            check("halt_no_issue", 32'(issue_valid), 32'd0);
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        reset     = 1'b1;
        start     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0;
        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_valid", 32'(issue_valid), 32'd0);
        check("rst_fields", {issue_op, issue_rd, issue_rx, issue_ry, issue_imm, issue_we}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req", 32'(imem_req), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Directed: RAW pair, LOADHI on rd match, NOPs, OUT, HALT at zero-wait memory
        stream = '{16'h7100, 16'h9400, 16'h7100, 16'hB03F, 16'hE000, 16'hF5C3,
                   16'hC100, 16'hD000};
        run_prog(0);

        // Random stream long enough to wrap the program counter; also restarts from HALTED
        stream.delete();
        for (int i = 0; i < 300; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hD) w[15:12] = 4'hE;
            stream.push_back(w);
        end
        stream.push_back(16'hD000);
        run_prog(2);

        // Reset mid-fetch drops imem_req at once; a late ack is ignored
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_req", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_req", 32'(imem_req), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 16'h7100;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_req", 32'(imem_req), 32'd0);
        check("late_ack_busy", 32'(busy), 32'd0);
        check("late_ack_valid", 32'(issue_valid), 32'd0);
        check("late_ack_we", 32'(issue_we), 32'd0);
        check("late_ack_pc", 32'(pc), 32'd0);

        // Recovery after reset
        stream = '{16'h7100, 16'h1540, 16'hA2AA, 16'hD000};
        run_prog(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
